// File: rtl/wb_arbiter.sv
// Writeback arbiter for the scalar and vector pipelines.
// When both pipelines write the same file in the same cycle, the scalar write
// goes first. The vector result is parked in a 1-entry buffer for that file.
// A full buffer drains first. Any scalar write that collides with a drain is
// stalled. Two saturating counters track conflict cycles and stall cycles.
module wb_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scalar_reg_req,
  input  logic             scalar_vec_req,
  input  logic             vector_reg_req,
  input  logic             vector_vec_req,
  input  logic             clr_counters,
  output logic             register_wb_sel,
  output logic             buffer_register_sel,
  output logic             buffer_register,
  output logic             vector_wb_sel,
  output logic             buffer_vector_sel,
  output logic             buffer_vector,
  output logic             scalar_wb_stall,
  output logic             reg_buf_full,
  output logic             vec_buf_full,
  output logic [CNT_W-1:0] conflict_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e reg_state_q, reg_state_d;
  buf_state_e vec_state_q, vec_state_d;

  logic [CNT_W-1:0] conflict_count_q, conflict_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic stall;
  logic s_reg, s_vec;
  logic reg_conflict, vec_conflict;
  logic reg_wb_sel_c, reg_buf_sel_c, reg_buffer_c;
  logic vec_wb_sel_c, vec_buf_sel_c, vec_buffer_c;

  // Buffer occupancy registers. Reset empties them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_state_q <= EMPTY;
      vec_state_q <= EMPTY;
    end else begin
      reg_state_q <= reg_state_d;
      vec_state_q <= vec_state_d;
    end
  end

  // Stall decision and the per-file select/capture logic, plus next buffer state.
  always_comb begin
    reg_state_d   = reg_state_q;
    vec_state_d   = vec_state_q;
    reg_wb_sel_c  = 1'b0;
    reg_buf_sel_c = 1'b0;
    reg_buffer_c  = 1'b0;
    vec_wb_sel_c  = 1'b0;
    vec_buf_sel_c = 1'b0;
    vec_buffer_c  = 1'b0;
    reg_conflict  = 1'b0;
    vec_conflict  = 1'b0;

    // A stall blocks the whole scalar instruction, so both of its writes are
    // suppressed even when only one file is colliding with a drain.
    stall = ((reg_state_q == FULL) && scalar_reg_req) ||
            ((vec_state_q == FULL) && scalar_vec_req);
    s_reg = scalar_reg_req && !stall;
    s_vec = scalar_vec_req && !stall;

    unique case (reg_state_q)
      EMPTY: begin
        reg_wb_sel_c = vector_reg_req && !s_reg;
        reg_buffer_c = vector_reg_req && s_reg;
        reg_conflict = vector_reg_req && s_reg;
        reg_state_d  = (vector_reg_req && s_reg) ? FULL : EMPTY;
      end
      FULL: begin
        reg_wb_sel_c  = 1'b1;
        reg_buf_sel_c = 1'b1;
        reg_buffer_c  = vector_reg_req;
        reg_state_d   = vector_reg_req ? FULL : EMPTY;
      end
      default: reg_state_d = EMPTY;
    endcase

    unique case (vec_state_q)
      EMPTY: begin
        vec_wb_sel_c = vector_vec_req && !s_vec;
        vec_buffer_c = vector_vec_req && s_vec;
        vec_conflict = vector_vec_req && s_vec;
        vec_state_d  = (vector_vec_req && s_vec) ? FULL : EMPTY;
      end
      FULL: begin
        vec_wb_sel_c  = 1'b1;
        vec_buf_sel_c = 1'b1;
        vec_buffer_c  = vector_vec_req;
        vec_state_d   = vector_vec_req ? FULL : EMPTY;
      end
      default: vec_state_d = EMPTY;
    endcase
  end

  // Drive outputs. All strobes are forced low while reset is held, even if requests are still active.
  always_comb begin
    register_wb_sel     = rst_n && reg_wb_sel_c;
    buffer_register_sel = rst_n && reg_buf_sel_c;
    buffer_register     = rst_n && reg_buffer_c;
    vector_wb_sel       = rst_n && vec_wb_sel_c;
    buffer_vector_sel   = rst_n && vec_buf_sel_c;
    buffer_vector       = rst_n && vec_buffer_c;
    scalar_wb_stall     = rst_n && stall;
    reg_buf_full        = (reg_state_q == FULL);
    vec_buf_full        = (vec_state_q == FULL);
    conflict_count      = conflict_count_q;
    stall_count         = stall_count_q;
  end

  // Next counter values. Both counters saturate, and clearing wins over incrementing.
  always_comb begin
    conflict_count_d = conflict_count_q;
    stall_count_d    = stall_count_q;
    if (clr_counters) begin
      conflict_count_d = '0;
      stall_count_d    = '0;
    end else begin
      if ((reg_conflict || vec_conflict) && (conflict_count_q != '1))
        conflict_count_d = conflict_count_q + 1'b1;
      if (stall && (stall_count_q != '1))
        stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_count_q <= '0;
      stall_count_q    <= '0;
    end else begin
      conflict_count_q <= conflict_count_d;
      stall_count_q    <= stall_count_d;
    end
  end

endmodule
